// File: rtl/mem_map_defs.sv
// Address map constants shared by the data-memory responder and its users.
package mem_map_defs;

    localparam logic [31:0] DMEM_BASE_DEF = 32'h1001_0000;
    localparam logic [31:0] IO_BASE_DEF   = 32'h1002_0000;

    // Word offsets within the I/O bank (byte offset >> 2)
    localparam logic [2:0] OFS_FIFO_DATA = 3'd0;
    localparam logic [2:0] OFS_FIFO_STAT = 3'd1;
    localparam logic [2:0] OFS_CYCLES    = 3'd2;
    localparam logic [2:0] OFS_LEDS      = 3'd3;

    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_OVF       = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous-reset FIFO with show-ahead output; push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Data-memory responder: decodes loads/stores to a data RAM and a small MMIO bank
// (keyboard FIFO, FIFO status, cycle counter, LEDs). Reads are combinational.
module mem_io_responder
    import mem_map_defs::*;
#(
    parameter int unsigned DMEM_WORDS = 1024,
    parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
    parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic [31:0] writedata,
    input  logic        mem_wr,
    input  logic        mem_rd,
    output logic [31:0] readmem,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic [15:0] leds
);

    localparam int unsigned AW = $clog2(DMEM_WORDS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_END = {1'b0, DMEM_BASE} + 33'(4 * DMEM_WORDS);

    logic [31:0] dmem [DMEM_WORDS];

    logic          ram_hit, io_hit;
    logic [AW-1:0] ram_idx;
    logic [2:0]    io_ofs;

    logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic          ovf_q, ovf_d;
    logic [31:0]   cycles_q, cycles_d;
    logic [15:0]   leds_q, leds_d;
    logic [31:0]   stat_word;
    logic          io_wr;

    assign ram_hit = ({1'b0, memaddr} >= {1'b0, DMEM_BASE}) && ({1'b0, memaddr} < RAM_END);
    assign ram_idx = memaddr[AW+1:2] - DMEM_BASE[AW+1:2];
    assign io_hit  = ~ram_hit && (memaddr[31:5] == IO_BASE[31:5]);
    assign io_ofs  = memaddr[4:2];
    assign io_wr   = mem_wr & io_hit & ~reset;

    // Ready is derived from the registered full flag, so a same-cycle pop never frees space early
    assign kbd_ready = ~fifo_full & ~reset;
    assign fifo_push = kbd_valid & kbd_ready;
    assign fifo_pop  = mem_rd & io_hit & (io_ofs == OFS_FIFO_DATA) & ~fifo_empty & ~reset;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (kbd_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        stat_word                           = '0;
        stat_word[STAT_EMPTY]               = fifo_empty;
        stat_word[STAT_FULL]                = fifo_full;
        stat_word[STAT_OVF]                 = ovf_q;
        stat_word[STAT_COUNT_LSB +: CW]     = fifo_count;
    end

    always_comb begin
        ovf_d    = ovf_q;
        cycles_d = cycles_q + 32'd1;
        leds_d   = leds_q;
        if (io_wr && io_ofs == OFS_FIFO_STAT && writedata[STAT_OVF]) ovf_d = 1'b0;
        // An overflow in the same cycle as a clear wins
        if (kbd_valid && fifo_full) ovf_d = 1'b1;
        if (io_wr && io_ofs == OFS_CYCLES) cycles_d = writedata;
        if (io_wr && io_ofs == OFS_LEDS)   leds_d   = writedata[15:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q    <= 1'b0;
            cycles_q <= '0;
            leds_q   <= '0;
        end else begin
            ovf_q    <= ovf_d;
            cycles_q <= cycles_d;
            leds_q   <= leds_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_wr && ram_hit) dmem[ram_idx] <= writedata;
    end

    always_comb begin
        readmem = '0;
        if (ram_hit) begin
            readmem = dmem[ram_idx];
        end else if (io_hit) begin
            case (io_ofs)
                OFS_FIFO_DATA: readmem = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
                OFS_FIFO_STAT: readmem = stat_word;
                OFS_CYCLES:    readmem = cycles_q;
                OFS_LEDS:      readmem = {16'd0, leds_q};
                default:       readmem = '0;
            endcase
        end
    end

    assign leds = leds_q;

endmodule
